// File: rtl/iob_wishbone2iob.sv
// Wishbone B4 classic slave to IOb native master bridge: one outstanding
// transfer, timeout-to-error on a dead IOb slave, and master-abort tolerance.
module iob_wishbone2iob #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic [ADDR_W-1:0]     wb_addr_i,
    input  logic [DATA_W-1:0]     wb_data_i,
    input  logic [DATA_W/8-1:0]   wb_select_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic [DATA_W-1:0]     wb_data_o,
    output logic                  wb_ack_o,
    output logic                  wb_err_o,
    output logic                  valid_o,
    output logic [ADDR_W-1:0]     address_o,
    output logic [DATA_W-1:0]     wdata_o,
    output logic [DATA_W/8-1:0]   wstrb_o,
    input  logic [DATA_W-1:0]     rdata_i,
    input  logic                  ready_i
);

    // Timer holds 0..TIMEOUT-1; it is cleared whenever a transfer starts.
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t              state_q;
    logic [TW-1:0]       timer_q;
    logic                we_q;
    logic                abort_q;
    logic                valid_q, ack_q, err_q;
    logic [DATA_W-1:0]   rdata_q, wdata_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W/8-1:0] wstrb_q;

    logic abort_d;
    logic timeout_hit;

    assign abort_d     = abort_q | ~wb_cyc_i;
    assign timeout_hit = (TIMEOUT != 0) && (timer_q == TO_LAST);

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q <= IDLE;
            timer_q <= '0;
            we_q    <= 1'b0;
            abort_q <= 1'b0;
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
            wdata_q <= '0;
            addr_q  <= '0;
            wstrb_q <= '0;
        end else begin
            valid_q <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (wb_cyc_i && wb_stb_i) begin
                        addr_q  <= wb_addr_i;
                        wdata_q <= wb_data_i;
                        wstrb_q <= wb_we_i ? wb_select_i : '0;
                        we_q    <= wb_we_i;
                        timer_q <= '0;
                        abort_q <= 1'b0;
                        // A write with no byte lanes has nothing to send to IOb.
                        if (wb_we_i && wb_select_i == '0) begin
                            state_q <= RESP;
                            ack_q   <= 1'b1;
                            rdata_q <= '0;
                        end else begin
                            state_q <= REQ;
                            valid_q <= 1'b1;
                        end
                    end
                end
                REQ, WAIT: begin
                    if (ready_i || timeout_hit) begin
                        abort_q <= 1'b0;
                        if (abort_d) begin
                            state_q <= IDLE;
                        end else begin
                            state_q <= RESP;
                            ack_q   <= ready_i;
                            err_q   <= ~ready_i;
                            rdata_q <= (ready_i && !we_q) ? rdata_i : '0;
                        end
                    end else begin
                        state_q <= WAIT;
                        timer_q <= timer_q + TW'(1);
                        abort_q <= abort_d;
                    end
                end
                RESP: state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign wb_data_o = rdata_q;
    assign wb_ack_o  = ack_q;
    assign wb_err_o  = err_q;
    assign valid_o   = valid_q;
    assign address_o = addr_q;
    assign wdata_o   = wdata_q;
    assign wstrb_o   = wstrb_q;

endmodule

// File: tb/tb_iob_wishbone2iob.sv
// Bench for iob_wishbone2iob: directed and random transfers compared against a
// cycle-count reference model of the bridge's observable behaviour.
module tb_iob_wishbone2iob;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        arst_n;
    logic [31:0] wb_addr, wb_data, wb_data_o, address_o, wdata_o, rdata;
    logic [3:0]  wb_sel, wstrb_o;
    logic        wb_we, wb_cyc, wb_stb, wb_ack_o, wb_err_o, valid_o, ready;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0]  vcnt;
        logic [3:0]  vcyc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [3:0]  acks;
        logic [3:0]  errs;
        logic [3:0]  rcyc;
        logic [31:0] rdata;
        logic        both;
    } obs_t;

    iob_wishbone2iob #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TO)) dut (
        .clk_i(clk), .arst_n_i(arst_n),
        .wb_addr_i(wb_addr), .wb_data_i(wb_data), .wb_select_i(wb_sel),
        .wb_we_i(wb_we), .wb_cyc_i(wb_cyc), .wb_stb_i(wb_stb),
        .wb_data_o(wb_data_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o),
        .valid_o(valid_o), .address_o(address_o), .wdata_o(wdata_o),
        .wstrb_o(wstrb_o), .rdata_i(rdata), .ready_i(ready)
    );

    always #5 clk = ~clk;

    // Expected observation: request in cycle 1, response in cycle 2+d, or an
    // error in cycle 1+TO if the slave is slower than the timeout.
    function automatic obs_t model(input logic we, input logic [3:0] sel,
                                   input logic [31:0] addr, input logic [31:0] data,
                                   input int d, input logic [31:0] rd, input bit abort);
        obs_t e = '0;
        if (we && sel == 4'h0) begin
            e.acks = 4'd1;
            e.rcyc = 4'd1;
            return e;
        end
        e.vcnt  = 4'd1;
        e.vcyc  = 4'd1;
        e.addr  = addr;
        e.wdata = data;
        e.wstrb = we ? sel : 4'h0;
        if (abort) return e;
        if (d >= TO) begin
            e.errs = 4'd1;
            e.rcyc = 4'(1 + TO);
        end else begin
            e.acks  = 4'd1;
            e.rcyc  = 4'(2 + d);
            e.rdata = we ? 32'h0 : rd;
        end
        return e;
    endfunction

    function automatic int window(input obs_t e, input bit b2b);
        if (e.acks == 0 && e.errs == 0) return 10;
        return b2b ? int'(e.rcyc) : int'(e.rcyc) + 2;
    endfunction

    task automatic idle(input int n);
        wb_cyc = 1'b0; wb_stb = 1'b0; ready = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Master side of one transfer plus IOb slave answering in cycle 1+d.
    task automatic run_xfer(input logic we, input logic [3:0] sel, input logic [31:0] addr,
                            input logic [31:0] data, input int d, input logic [31:0] rd,
                            input int abort_at, input bit b2b, input int win, output obs_t o);
        o = '0;
        @(negedge clk);
        wb_cyc = 1'b1; wb_stb = 1'b1; wb_we = we; wb_sel = sel;
        wb_addr = addr; wb_data = data;
        ready = 1'($urandom);
        rdata = $urandom;
        for (int c = 1; c <= win; c++) begin
            @(negedge clk);
            if (valid_o) begin
                o.vcnt = o.vcnt + 4'd1;
                if (o.vcyc == 0) begin
                    o.vcyc = 4'(c); o.addr = address_o; o.wdata = wdata_o; o.wstrb = wstrb_o;
                end
            end
            if (wb_ack_o) o.acks = o.acks + 4'd1;
            if (wb_err_o) o.errs = o.errs + 4'd1;
            if (wb_ack_o && wb_err_o) o.both = 1'b1;
            if ((wb_ack_o || wb_err_o) && o.rcyc == 0) begin
                o.rcyc = 4'(c); o.rdata = wb_data_o;
            end
            if (abort_at == c || ((wb_ack_o || wb_err_o) && !b2b)) begin
                wb_cyc = 1'b0; wb_stb = 1'b0;
            end
            ready = (c == 1 + d);
            rdata = (c == 1 + d) ? rd : $urandom;
        end
    endtask

    task automatic test_reset;
        arst_n = 1'b0;
        idle(2);
        n_tests++;
        if ({wb_data_o, wb_ack_o, wb_err_o, valid_o, address_o, wdata_o, wstrb_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got ack=%b err=%b valid=%b addr=%h data=%h exp all 0",
                     wb_ack_o, wb_err_o, valid_o, address_o, wb_data_o);
        end
        arst_n = 1'b1;
        idle(2);
    endtask

    task automatic test_read;
        obs_t o, e;
        e = model(1'b0, 4'hF, 32'h10, 32'h0, 2, 32'hDEADBEEF, 1'b0);
        run_xfer(1'b0, 4'hF, 32'h10, 32'h0, 2, 32'hDEADBEEF, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL read_obs: got %h exp %h", o, e); end
        n_tests++;
        if (o.rcyc !== 4'd4 || o.rdata !== 32'hDEADBEEF) begin
            n_fail++; $display("FAIL read_ack: got cyc %0d data %h exp cyc 4 data deadbeef", o.rcyc, o.rdata);
        end
        n_tests++;
        if (o.wstrb !== 4'h0 || o.errs !== 4'd0) begin
            n_fail++; $display("FAIL read_wstrb: got wstrb %h errs %0d exp 0 0", o.wstrb, o.errs);
        end
        idle(1);
    endtask

    task automatic test_write;
        obs_t o, e;
        e = model(1'b1, 4'h3, 32'h20, 32'h12345678, 0, 32'hFFFFFFFF, 1'b0);
        run_xfer(1'b1, 4'h3, 32'h20, 32'h12345678, 0, 32'hFFFFFFFF, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL write_obs: got %h exp %h", o, e); end
        n_tests++;
        if (o.addr !== 32'h20 || o.wdata !== 32'h12345678 || o.wstrb !== 4'h3) begin
            n_fail++; $display("FAIL write_req: got %h %h %h exp 20 12345678 3", o.addr, o.wdata, o.wstrb);
        end
        n_tests++;
        if (o.rcyc !== 4'd2 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL write_ack: got cyc %0d data %h exp cyc 2 data 0", o.rcyc, o.rdata);
        end
        idle(1);
    endtask

    task automatic test_write_nosel;
        obs_t o, e;
        e = model(1'b1, 4'h0, 32'h44, 32'hCAFEF00D, 0, 32'h5A5A5A5A, 1'b0);
        run_xfer(1'b1, 4'h0, 32'h44, 32'hCAFEF00D, 0, 32'h5A5A5A5A, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL nosel_obs: got %h exp %h", o, e); end
        n_tests++;
        if (o.vcnt !== 4'd0 || o.rcyc !== 4'd1) begin
            n_fail++; $display("FAIL nosel_ack: got valids %0d ack cyc %0d exp 0 1", o.vcnt, o.rcyc);
        end
        idle(1);
    endtask

    task automatic test_timeout;
        obs_t o, e;
        e = model(1'b0, 4'hF, 32'h80, 32'h0, 99, 32'h11111111, 1'b0);
        run_xfer(1'b0, 4'hF, 32'h80, 32'h0, 99, 32'h11111111, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL timeout_obs: got %h exp %h", o, e); end
        n_tests++;
        if (o.errs !== 4'd1 || o.acks !== 4'd0 || o.rcyc !== 4'd5 || o.rdata !== 32'h0) begin
            n_fail++; $display("FAIL timeout_err: got errs %0d acks %0d cyc %0d exp 1 0 5", o.errs, o.acks, o.rcyc);
        end
        idle(1);
        e = model(1'b0, 4'hF, 32'h84, 32'h0, 3, 32'h22222222, 1'b0);
        run_xfer(1'b0, 4'hF, 32'h84, 32'h0, 3, 32'h22222222, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL late_ready_obs: got %h exp %h", o, e); end
        n_tests++;
        if (o.acks !== 4'd1 || o.errs !== 4'd0 || o.rcyc !== 4'd5) begin
            n_fail++; $display("FAIL late_ready_ack: got acks %0d errs %0d cyc %0d exp 1 0 5", o.acks, o.errs, o.rcyc);
        end
        idle(1);
    endtask

    task automatic test_abort;
        obs_t o, e;
        e = model(1'b0, 4'hF, 32'h90, 32'h0, 3, 32'h33333333, 1'b1);
        run_xfer(1'b0, 4'hF, 32'h90, 32'h0, 3, 32'h33333333, 2, 1'b0, 10, o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL abort_obs: got %h exp %h", o, e); end
        n_tests++;
        if (o.acks !== 4'd0 || o.errs !== 4'd0) begin
            n_fail++; $display("FAIL abort_noresp: got acks %0d errs %0d exp 0 0", o.acks, o.errs);
        end
        e = model(1'b0, 4'hF, 32'h94, 32'h0, 1, 32'h44444444, 1'b0);
        run_xfer(1'b0, 4'hF, 32'h94, 32'h0, 1, 32'h44444444, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL abort_followup: got %h exp %h", o, e); end
        idle(1);
    endtask

    task automatic test_back_to_back;
        obs_t o, e;
        logic we; logic [3:0] sel; logic [31:0] a, dt, rd; int d;
        for (int i = 0; i < 6; i++) begin
            we = 1'($urandom); sel = 4'($urandom_range(1, 15));
            a = $urandom; dt = $urandom; rd = $urandom; d = $urandom_range(0, TO - 1);
            e = model(we, sel, a, dt, d, rd, 1'b0);
            run_xfer(we, sel, a, dt, d, rd, 0, 1'b1, window(e, 1'b1), o);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL b2b_%0d: got %h exp %h", i, o, e); end
        end
        idle(2);
    endtask

    task automatic test_random;
        obs_t o, e;
        logic we; logic [3:0] sel; logic [31:0] a, dt, rd; int d, ab, comp;
        for (int i = 0; i < 40; i++) begin
            we  = 1'($urandom); sel = ($urandom_range(0, 3) == 0) ? 4'h0 : 4'($urandom);
            a   = $urandom; dt = $urandom; rd = $urandom;
            d   = $urandom_range(0, TO + 1);
            ab  = 0;
            if (!(we && sel == 4'h0) && $urandom_range(0, 5) == 0) begin
                if (d == 0) d = $urandom_range(1, TO + 1);
                comp = (d < TO) ? 1 + d : TO;
                ab = $urandom_range(1, comp - 1);
            end
            e = model(we, sel, a, dt, d, rd, ab != 0);
            run_xfer(we, sel, a, dt, d, rd, ab, 1'b0, window(e, 1'b0), o);
            n_tests++;
            if (o !== e) begin n_fail++; $display("FAIL random_%0d: got %h exp %h", i, o, e); end
            idle($urandom_range(0, 2));
        end
    endtask

    task automatic test_reset_mid;
        obs_t o, e;
        run_xfer(1'b1, 4'hF, 32'hA5A5_0000, 32'h0F0F0F0F, 99, 32'h0, 0, 1'b1, 2, o);
        arst_n = 1'b0;
        #1;
        n_tests++;
        if ({wb_data_o, wb_ack_o, wb_err_o, valid_o, address_o, wdata_o, wstrb_o} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_outputs: got addr=%h wdata=%h wstrb=%h exp all 0",
                     address_o, wdata_o, wstrb_o);
        end
        idle(1);
        arst_n = 1'b1;
        e = model(1'b0, 4'hF, 32'hB0, 32'h0, 1, 32'h89ABCDEF, 1'b0);
        run_xfer(1'b0, 4'hF, 32'hB0, 32'h0, 1, 32'h89ABCDEF, 0, 1'b0, window(e, 1'b0), o);
        n_tests++;
        if (o !== e) begin n_fail++; $display("FAIL reset_mid_read: got %h exp %h", o, e); end
        idle(1);
    endtask

    initial begin
        wb_addr = '0; wb_data = '0; wb_sel = '0; wb_we = 1'b0;
        wb_cyc = 1'b0; wb_stb = 1'b0; rdata = '0; ready = 1'b0;
        test_reset;
        test_read;
        test_write;
        test_write_nosel;
        test_timeout;
        test_abort;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
